// File: rtl/control_unidad_segmentada_if.sv
// ID-stage instruction fields in, registered EX-stage control word out.
interface control_unidad_segmentada_if #(
  parameter int NBITS     = 6,
  parameter int FBITS     = 6,
  parameter int RBITS     = 5,
  parameter int ALUOPBITS = 3
);
  logic                 i_Valid;
  logic [NBITS-1:0]     i_Opcode;
  logic [FBITS-1:0]     i_Funct;
  logic [RBITS-1:0]     i_Rs;
  logic [RBITS-1:0]     i_Rt;
  logic                 i_Flush;
  logic                 o_Stall;
  logic                 o_Valid;
  logic [1:0]           o_RegDst;
  logic                 o_Jump, o_JumpReg, o_Branch, o_BranchNe, o_MemRead, o_MemToReg;
  logic                 o_MemWrite, o_ALUSrc, o_RegWrite, o_ExtZero, o_Link;
  logic [ALUOPBITS-1:0] o_ALUOp;
  logic [RBITS-1:0]     o_Rt;
  logic                 o_IllegalOp;
  logic                 o_Halted;

  modport master (
    output i_Valid, i_Opcode, i_Funct, i_Rs, i_Rt, i_Flush,
    input  o_Stall, o_Valid, o_RegDst, o_Jump, o_JumpReg, o_Branch, o_BranchNe,
           o_MemRead, o_MemToReg, o_MemWrite, o_ALUSrc, o_RegWrite, o_ExtZero,
           o_Link, o_ALUOp, o_Rt, o_IllegalOp, o_Halted
  );

  modport slave (
    input  i_Valid, i_Opcode, i_Funct, i_Rs, i_Rt, i_Flush,
    output o_Stall, o_Valid, o_RegDst, o_Jump, o_JumpReg, o_Branch, o_BranchNe,
           o_MemRead, o_MemToReg, o_MemWrite, o_ALUSrc, o_RegWrite, o_ExtZero,
           o_Link, o_ALUOp, o_Rt, o_IllegalOp, o_Halted
  );
endinterface

// File: rtl/control_unidad_segmentada.sv
// Pipelined main decoder: ID decode, load-use hazard detection, ID/EX control
// register with bubble insertion on stall, flush, illegal opcode and halt.
module control_unidad_segmentada #(
  parameter int NBITS     = 6,
  parameter int FBITS     = 6,
  parameter int RBITS     = 5,
  parameter int ALUOPBITS = 3
) (
  input logic i_clk,
  input logic i_reset,
  control_unidad_segmentada_if.slave bus
);
  typedef struct packed {
    logic [1:0]           reg_dst;
    logic                 jump, jump_reg, branch, branch_ne, mem_read, mem_to_reg;
    logic                 mem_write, alu_src, reg_write, ext_zero, link;
    logic [ALUOPBITS-1:0] alu_op;
  } ctrl_t;

  ctrl_t            dec, bubble, ctrl_d, ctrl_q;
  logic             illegal, is_halt, uses_rs, uses_rt, stall;
  logic             valid_d, valid_q, ill_d, ill_q, halted_d, halted_q;
  logic [RBITS-1:0] rt_d, rt_q;

  always_comb begin
    bubble        = '0;
    bubble.alu_op = '1;
  end

  always_comb begin
    dec     = '0;
    illegal = 1'b0;
    is_halt = 1'b0;
    uses_rs = 1'b1;
    uses_rt = 1'b0;
    case (bus.i_Opcode)
      6'b000000: begin
        if (bus.i_Funct == 6'b001000) begin
          dec.reg_dst  = 2'b01;
          dec.jump_reg = 1'b1;
          dec.alu_op   = '1;
        end else begin
          dec.reg_dst   = 2'b01;
          dec.reg_write = 1'b1;
          dec.alu_op    = ALUOPBITS'(3'b010);
          uses_rt       = 1'b1;
        end
      end
      6'b100011: begin
        dec.alu_src = 1'b1; dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1; dec.reg_write = 1'b1;
      end
      6'b101011: begin
        dec.alu_src = 1'b1; dec.mem_write = 1'b1; uses_rt = 1'b1;
      end
      6'b000100: begin
        dec.branch = 1'b1; dec.alu_op = ALUOPBITS'(3'b001); uses_rt = 1'b1;
      end
      6'b000101: begin
        dec.branch = 1'b1; dec.branch_ne = 1'b1; dec.alu_op = ALUOPBITS'(3'b001); uses_rt = 1'b1;
      end
      6'b000010: begin
        dec.jump = 1'b1; dec.alu_op = '1; uses_rs = 1'b0;
      end
      6'b000011: begin
        dec.jump = 1'b1; dec.link = 1'b1; dec.reg_write = 1'b1;
        dec.reg_dst = 2'b10; dec.alu_op = '1; uses_rs = 1'b0;
      end
      6'b001000: begin
        dec.alu_src = 1'b1; dec.reg_write = 1'b1;
      end
      6'b001100: begin
        dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.ext_zero = 1'b1; dec.alu_op = ALUOPBITS'(3'b011);
      end
      6'b001101: begin
        dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.ext_zero = 1'b1; dec.alu_op = ALUOPBITS'(3'b100);
      end
      6'b001111: begin
        dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = ALUOPBITS'(3'b101); uses_rs = 1'b0;
      end
      6'b111111: begin
        is_halt = 1'b1; uses_rs = 1'b0;
      end
      default: begin
        illegal = 1'b1; uses_rs = 1'b0;
      end
    endcase
  end

  // Gated by reset so the stall drops the moment reset asserts.
  assign stall = !i_reset && bus.i_Valid && !bus.i_Flush && !halted_q && valid_q &&
                 ctrl_q.mem_read && (rt_q != '0) &&
                 ((uses_rs && rt_q == bus.i_Rs) || (uses_rt && rt_q == bus.i_Rt));

  always_comb begin
    ctrl_d   = bubble;
    valid_d  = 1'b0;
    rt_d     = '0;
    ill_d    = 1'b0;
    halted_d = halted_q;
    if (!(halted_q || bus.i_Flush || stall)) begin
      if (!bus.i_Valid || illegal) begin
        ill_d = bus.i_Valid && illegal;
      end else if (is_halt) begin
        halted_d = 1'b1;
      end else begin
        ctrl_d  = dec;
        valid_d = 1'b1;
        rt_d    = bus.i_Rt;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      ctrl_q   <= '0;
      valid_q  <= 1'b0;
      rt_q     <= '0;
      ill_q    <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      valid_q  <= valid_d;
      rt_q     <= rt_d;
      ill_q    <= ill_d;
      halted_q <= halted_d;
    end
  end

  assign bus.o_Stall     = stall;
  assign bus.o_Valid     = valid_q;
  assign bus.o_RegDst    = ctrl_q.reg_dst;
  assign bus.o_Jump      = ctrl_q.jump;
  assign bus.o_JumpReg   = ctrl_q.jump_reg;
  assign bus.o_Branch    = ctrl_q.branch;
  assign bus.o_BranchNe  = ctrl_q.branch_ne;
  assign bus.o_MemRead   = ctrl_q.mem_read;
  assign bus.o_MemToReg  = ctrl_q.mem_to_reg;
  assign bus.o_MemWrite  = ctrl_q.mem_write;
  assign bus.o_ALUSrc    = ctrl_q.alu_src;
  assign bus.o_RegWrite  = ctrl_q.reg_write;
  assign bus.o_ExtZero   = ctrl_q.ext_zero;
  assign bus.o_Link      = ctrl_q.link;
  assign bus.o_ALUOp     = ctrl_q.alu_op;
  assign bus.o_Rt        = rt_q;
  assign bus.o_IllegalOp = ill_q;
  assign bus.o_Halted    = halted_q;
endmodule

// File: tb/tb_control_unidad_segmentada.sv
// Directed bench for the pipelined decoder: decode words, load-use stalls,
// flush, illegal opcode, halt and asynchronous reset.
module tb_control_unidad_segmentada;
  logic i_clk = 1'b0;
  logic i_reset;
  int   total = 0;
  int   bad   = 0;

  control_unidad_segmentada_if ifc ();
  control_unidad_segmentada dut (.i_clk(i_clk), .i_reset(i_reset), .bus(ifc.slave));

  always #5 i_clk = ~i_clk;

  // {RegDst, Jump, JumpReg, Branch, BranchNe, MemRead, MemToReg, MemWrite,
  //  ALUSrc, RegWrite, ExtZero, Link, ALUOp}
  localparam logic [15:0] CW_BUB  = {2'b00, 11'b00000000000, 3'b111};
  localparam logic [15:0] CW_ADD  = {2'b01, 11'b00000000100, 3'b010};
  localparam logic [15:0] CW_LW   = {2'b00, 11'b00001101100, 3'b000};
  localparam logic [15:0] CW_SW   = {2'b00, 11'b00000011000, 3'b000};
  localparam logic [15:0] CW_ADDI = {2'b00, 11'b00000001100, 3'b000};
  localparam logic [15:0] CW_JAL  = {2'b10, 11'b10000000101, 3'b111};
  localparam logic [15:0] CW_JR   = {2'b01, 11'b01000000000, 3'b111};

  function automatic logic [15:0] cw();
    return {ifc.o_RegDst, ifc.o_Jump, ifc.o_JumpReg, ifc.o_Branch, ifc.o_BranchNe,
            ifc.o_MemRead, ifc.o_MemToReg, ifc.o_MemWrite, ifc.o_ALUSrc,
            ifc.o_RegWrite, ifc.o_ExtZero, ifc.o_Link, ifc.o_ALUOp};
  endfunction

  task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic fl);
    ifc.i_Valid = v; ifc.i_Opcode = op; ifc.i_Funct = fn;
    ifc.i_Rs = rs; ifc.i_Rt = rt; ifc.i_Flush = fl;
    #1;
  endtask

  task automatic step();
    @(posedge i_clk); #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 1'b0);
    i_reset = 1'b1;
    #12;
    total++; if (cw() !== 16'h0000) begin bad++; $display("FAIL reset_cw got=%h exp=%h", cw(), 16'h0000); end
    total++; if ({ifc.o_Valid, ifc.o_Halted, ifc.o_Stall, ifc.o_IllegalOp} !== 4'b0000) begin bad++;
      $display("FAIL reset_flags got=%b exp=0000", {ifc.o_Valid, ifc.o_Halted, ifc.o_Stall, ifc.o_IllegalOp}); end
    @(negedge i_clk); i_reset = 1'b0;
  endtask

  task automatic test_add();
    @(posedge i_clk); #1;
    drive(1'b1, 6'b000000, 6'b100000, 5'd1, 5'd2, 1'b0);
    step();
    total++; if (cw() !== CW_ADD) begin bad++; $display("FAIL add_cw got=%h exp=%h", cw(), CW_ADD); end
    total++; if (ifc.o_Valid !== 1'b1 || ifc.o_Rt !== 5'd2) begin bad++;
      $display("FAIL add_valid_rt got=%b/%0d exp=1/2", ifc.o_Valid, ifc.o_Rt); end
  endtask

  task automatic test_load_use();
    drive(1'b1, 6'b100011, 6'd0, 5'd1, 5'd5, 1'b0);
    step();
    total++; if (cw() !== CW_LW) begin bad++; $display("FAIL lw_cw got=%h exp=%h", cw(), CW_LW); end
    drive(1'b1, 6'b000000, 6'b100000, 5'd5, 5'd2, 1'b0);
    total++; if (ifc.o_Stall !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b exp=1", ifc.o_Stall); end
    step();
    total++; if (ifc.o_Valid !== 1'b0 || cw() !== CW_BUB || ifc.o_Stall !== 1'b0) begin bad++;
      $display("FAIL lu_bubble got=%b/%h/%b exp=0/%h/0", ifc.o_Valid, cw(), ifc.o_Stall, CW_BUB); end
    step();
    total++; if (cw() !== CW_ADD || ifc.o_Valid !== 1'b1) begin bad++;
      $display("FAIL lu_release got=%h/%b exp=%h/1", cw(), ifc.o_Valid, CW_ADD); end
    drive(1'b1, 6'b100011, 6'd0, 5'd1, 5'd0, 1'b0);
    step();
    drive(1'b1, 6'b000000, 6'b100000, 5'd0, 5'd0, 1'b0);
    total++; if (ifc.o_Stall !== 1'b0) begin bad++; $display("FAIL lu_rt0_stall got=%b exp=0", ifc.o_Stall); end
    step();
    total++; if (cw() !== CW_ADD) begin bad++; $display("FAIL lu_rt0_add got=%h exp=%h", cw(), CW_ADD); end
  endtask

  task automatic test_sw_addi();
    drive(1'b1, 6'b100011, 6'd0, 5'd1, 5'd7, 1'b0);
    step();
    drive(1'b1, 6'b101011, 6'd0, 5'd1, 5'd7, 1'b0);
    total++; if (ifc.o_Stall !== 1'b1) begin bad++; $display("FAIL sw_stall got=%b exp=1", ifc.o_Stall); end
    step(); step();
    total++; if (cw() !== CW_SW) begin bad++; $display("FAIL sw_cw got=%h exp=%h", cw(), CW_SW); end
    drive(1'b1, 6'b100011, 6'd0, 5'd1, 5'd7, 1'b0);
    step();
    drive(1'b1, 6'b001000, 6'd0, 5'd1, 5'd7, 1'b0);
    total++; if (ifc.o_Stall !== 1'b0) begin bad++; $display("FAIL addi_stall got=%b exp=0", ifc.o_Stall); end
    step();
    total++; if (cw() !== CW_ADDI) begin bad++; $display("FAIL addi_cw got=%h exp=%h", cw(), CW_ADDI); end
  endtask

  task automatic test_jal_jr();
    drive(1'b1, 6'b000011, 6'd0, 5'd0, 5'd0, 1'b0);
    step();
    total++; if (cw() !== CW_JAL) begin bad++; $display("FAIL jal_cw got=%h exp=%h", cw(), CW_JAL); end
    drive(1'b1, 6'b000000, 6'b001000, 5'd31, 5'd0, 1'b0);
    step();
    total++; if (cw() !== CW_JR) begin bad++; $display("FAIL jr_cw got=%h exp=%h", cw(), CW_JR); end
  endtask

  task automatic test_flush_illegal();
    drive(1'b1, 6'b100011, 6'd0, 5'd1, 5'd5, 1'b0);
    step();
    drive(1'b1, 6'b000000, 6'b100000, 5'd5, 5'd2, 1'b1);
    total++; if (ifc.o_Stall !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", ifc.o_Stall); end
    step();
    total++; if (cw() !== CW_BUB || ifc.o_Valid !== 1'b0) begin bad++;
      $display("FAIL flush_bubble got=%h/%b exp=%h/0", cw(), ifc.o_Valid, CW_BUB); end
    drive(1'b1, 6'b010011, 6'd0, 5'd1, 5'd2, 1'b0);
    step();
    total++; if (ifc.o_IllegalOp !== 1'b1 || ifc.o_Valid !== 1'b0 || cw() !== CW_BUB) begin bad++;
      $display("FAIL illegal_pulse got=%b/%b/%h exp=1/0/%h", ifc.o_IllegalOp, ifc.o_Valid, cw(), CW_BUB); end
    drive(1'b0, 6'd0, 6'd0, 5'd0, 5'd0, 1'b0);
    step();
    total++; if (ifc.o_IllegalOp !== 1'b0) begin bad++; $display("FAIL illegal_clear got=%b exp=0", ifc.o_IllegalOp); end
  endtask

  task automatic test_halt();
    drive(1'b1, 6'b111111, 6'd0, 5'd0, 5'd0, 1'b0);
    step();
    total++; if (ifc.o_Halted !== 1'b1 || ifc.o_Valid !== 1'b0) begin bad++;
      $display("FAIL halt_set got=%b/%b exp=1/0", ifc.o_Halted, ifc.o_Valid); end
    drive(1'b1, 6'b000000, 6'b100000, 5'd1, 5'd2, 1'b0);
    step();
    total++; if (ifc.o_Valid !== 1'b0 || cw() !== CW_BUB || ifc.o_Halted !== 1'b1) begin bad++;
      $display("FAIL halt_bubble got=%b/%h/%b exp=0/%h/1", ifc.o_Valid, cw(), ifc.o_Halted, CW_BUB); end
    #2; i_reset = 1'b1; #1;
    total++; if (ifc.o_Halted !== 1'b0 || cw() !== 16'h0000) begin bad++;
      $display("FAIL halt_reset got=%b/%h exp=0/0000", ifc.o_Halted, cw()); end
    @(negedge i_clk); i_reset = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    @(posedge i_clk); #1;
    drive(1'b1, 6'b100011, 6'd0, 5'd1, 5'd3, 1'b0);
    step();
    drive(1'b1, 6'b000000, 6'b100000, 5'd3, 5'd4, 1'b0);
    total++; if (ifc.o_Stall !== 1'b1) begin bad++; $display("FAIL mid_stall_pre got=%b exp=1", ifc.o_Stall); end
    i_reset = 1'b1; #1;
    total++; if (ifc.o_Stall !== 1'b0 || ifc.o_Valid !== 1'b0 || ifc.o_MemRead !== 1'b0) begin bad++;
      $display("FAIL mid_stall_reset got=%b/%b/%b exp=0/0/0", ifc.o_Stall, ifc.o_Valid, ifc.o_MemRead); end
    @(negedge i_clk); i_reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_use();
    test_sw_addi();
    test_jal_jr();
    test_flush_illegal();
    test_halt();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
